// File: rtl/mdio_phy_manager.sv
// mdio_phy_manager
//   Drives an MDIO master through its AXI-Lite slave port. After reset the PHY
//   is soft-reset, the reset bit is polled until it self-clears, the
//   auto-negotiation advertisement is programmed and auto-negotiation is
//   restarted. Afterwards the link bit of BMSR is polled periodically, and a
//   single host request port can read or write PHY registers between polls.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   axi_aw*/axi_w*/axi_b*   AXI-Lite write channels (5-bit addr, 16-bit data)
//   axi_ar*/axi_r*          AXI-Lite read channels
//   host_req_*_i/_o         host request (valid/ready, write, addr, wdata)
//   host_rsp_valid_o        one-cycle pulse when a host transaction finishes
//   host_rsp_rdata_o        read data of the last host transaction (0 for writes)
//   init_done_o             init sequence completed (sticky)
//   init_error_o            PHY reset never self-cleared (sticky)
//   link_up_o               BMSR link bit from the latest poll
//   link_status_valid_o     at least one poll has completed (sticky)
module mdio_phy_manager #(
  parameter int unsigned POLL_INTERVAL_CYCLES = 12_500_000,
  parameter int unsigned RESET_POLL_LIMIT     = 16,
  parameter logic [15:0] ANAR_VALUE           = 16'h01E1,
  parameter logic [15:0] BMCR_ANEG_VALUE      = 16'h1200
) (
  input  logic        clk,
  input  logic        reset,
  // AXI-Lite master towards the MDIO master
  output logic        axi_awvalid_o,
  output logic [4:0]  axi_awaddr_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [15:0] axi_wdata_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [4:0]  axi_araddr_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [15:0] axi_rdata_i,
  output logic        axi_rready_o,
  // host register-access port
  input  logic        host_req_valid_i,
  output logic        host_req_ready_o,
  input  logic        host_req_write_i,
  input  logic [4:0]  host_req_addr_i,
  input  logic [15:0] host_req_wdata_i,
  output logic        host_rsp_valid_o,
  output logic [15:0] host_rsp_rdata_o,
  // status
  output logic        init_done_o,
  output logic        init_error_o,
  output logic        link_up_o,
  output logic        link_status_valid_o
);

  localparam logic [2:0] RST_WR    = 3'd0;
  localparam logic [2:0] RST_POLL  = 3'd1;
  localparam logic [2:0] ANAR_WR   = 3'd2;
  localparam logic [2:0] ANEG_WR   = 3'd3;
  localparam logic [2:0] IDLE      = 3'd4;
  localparam logic [2:0] HOST_XFER = 3'd5;
  localparam logic [2:0] POLL1     = 3'd6;
  localparam logic [2:0] POLL2     = 3'd7;

  localparam int unsigned TW = $clog2(POLL_INTERVAL_CYCLES);
  localparam int unsigned CW = $clog2(RESET_POLL_LIMIT) + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(POLL_INTERVAL_CYCLES - 1);
  localparam logic [CW-1:0] RST_LIMIT = CW'(RESET_POLL_LIMIT);

  logic [2:0]    state_q, state_d;
  logic          aw_pend_q, aw_pend_d;
  logic          w_pend_q, w_pend_d;
  logic          b_wait_q, b_wait_d;
  logic          ar_pend_q, ar_pend_d;
  logic          r_wait_q, r_wait_d;
  logic [4:0]    awaddr_q, awaddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [4:0]    araddr_q, araddr_d;
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          poll_due_q, poll_due_d;
  logic          init_done_q, init_done_d;
  logic          init_error_q, init_error_d;
  logic          link_up_q, link_up_d;
  logic          link_valid_q, link_valid_d;
  logic          host_write_q, host_write_d;
  logic [4:0]    host_addr_q, host_addr_d;
  logic [15:0]   host_wdata_q, host_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;

  // Transaction descriptor implied by the current state.
  logic          xfer_state;
  logic          xfer_write;
  logic [4:0]    xfer_addr;
  logic [15:0]   xfer_wdata;

  always_comb begin
    xfer_state = 1'b1;
    xfer_write = 1'b0;
    xfer_addr  = 5'd0;
    xfer_wdata = 16'h0000;
    case (state_q)
      RST_WR: begin
        xfer_write = 1'b1;
        xfer_wdata = 16'h8000;
      end
      RST_POLL: ;
      ANAR_WR: begin
        xfer_write = 1'b1;
        xfer_addr  = 5'd4;
        xfer_wdata = ANAR_VALUE;
      end
      ANEG_WR: begin
        xfer_write = 1'b1;
        xfer_wdata = BMCR_ANEG_VALUE;
      end
      HOST_XFER: begin
        xfer_write = host_write_q;
        xfer_addr  = host_addr_q;
        xfer_wdata = host_wdata_q;
      end
      POLL1, POLL2: xfer_addr = 5'd1;
      default: xfer_state = 1'b0;
    endcase
  end

  // A transaction is in flight while any channel is pending; a new one is
  // launched on the first cycle of a transaction state with nothing pending,
  // so repeating RST_POLL naturally re-issues the read one cycle later.
  logic busy;
  logic start;
  logic b_done;
  logic r_done;
  logic xfer_done;

  assign busy      = aw_pend_q | w_pend_q | b_wait_q | ar_pend_q | r_wait_q;
  assign start     = xfer_state & ~busy;
  assign b_done    = b_wait_q & axi_bvalid_i;
  assign r_done    = r_wait_q & axi_rvalid_i;
  assign xfer_done = b_done | r_done;

  always_comb begin
    state_d      = state_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    b_wait_d     = b_wait_q;
    ar_pend_d    = ar_pend_q;
    r_wait_d     = r_wait_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    araddr_d     = araddr_q;
    rst_cnt_d    = rst_cnt_q;
    timer_d      = timer_q;
    poll_due_d   = poll_due_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    link_up_d    = link_up_q;
    link_valid_d = link_valid_q;
    host_write_d = host_write_q;
    host_addr_d  = host_addr_q;
    host_wdata_d = host_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;

    // ---------------- AXI-Lite channel engine ----------------
    if (start) begin
      if (xfer_write) begin
        aw_pend_d = 1'b1;
        w_pend_d  = 1'b1;
        awaddr_d  = xfer_addr;
        wdata_d   = xfer_wdata;
      end else begin
        ar_pend_d = 1'b1;
        araddr_d  = xfer_addr;
      end
    end
    if (aw_pend_q && axi_awready_i) aw_pend_d = 1'b0;
    if (w_pend_q && axi_wready_i)   w_pend_d  = 1'b0;
    // Response phase opens once both address and data have been taken.
    if ((aw_pend_q || w_pend_q) && !aw_pend_d && !w_pend_d) b_wait_d = 1'b1;
    if (b_done) b_wait_d = 1'b0;
    if (ar_pend_q && axi_arready_i) begin
      ar_pend_d = 1'b0;
      r_wait_d  = 1'b1;
    end
    if (r_done) r_wait_d = 1'b0;

    // ---------------- sequencer ----------------
    case (state_q)
      RST_WR: if (xfer_done) state_d = RST_POLL;
      RST_POLL: begin
        if (xfer_done) begin
          if (!axi_rdata_i[15]) begin
            state_d = ANAR_WR;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_d == RST_LIMIT) begin
              init_error_d = 1'b1;
              state_d      = IDLE;
            end
          end
        end
      end
      ANAR_WR: if (xfer_done) state_d = ANEG_WR;
      ANEG_WR: begin
        if (xfer_done) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        // Host wins over a pending poll; the poll stays pending.
        if (host_req_valid_i) begin
          host_write_d = host_req_write_i;
          host_addr_d  = host_req_addr_i;
          host_wdata_d = host_req_wdata_i;
          state_d      = HOST_XFER;
        end else if (poll_due_q && !init_error_q) begin
          state_d = POLL1;
        end
      end
      HOST_XFER: begin
        if (xfer_done) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = host_write_q ? 16'h0000 : axi_rdata_i;
          state_d     = IDLE;
        end
      end
      POLL1: if (xfer_done) state_d = POLL2;
      default: begin  // POLL2
        if (xfer_done) begin
          link_up_d    = axi_rdata_i[2];
          link_valid_d = 1'b1;
          poll_due_d   = 1'b0;
          state_d      = IDLE;
        end
      end
    endcase

    // ---------------- poll timer ----------------
    // Evaluated after the sequencer so a wrap coinciding with a poll
    // completion leaves the next poll pending.
    if (init_done_q || init_error_q) begin
      if (timer_q == TIMER_MAX) begin
        timer_d    = '0;
        poll_due_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RST_WR;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      b_wait_q     <= 1'b0;
      ar_pend_q    <= 1'b0;
      r_wait_q     <= 1'b0;
      awaddr_q     <= 5'd0;
      wdata_q      <= 16'h0000;
      araddr_q     <= 5'd0;
      rst_cnt_q    <= '0;
      timer_q      <= '0;
      poll_due_q   <= 1'b0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      link_up_q    <= 1'b0;
      link_valid_q <= 1'b0;
      host_write_q <= 1'b0;
      host_addr_q  <= 5'd0;
      host_wdata_q <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      b_wait_q     <= b_wait_d;
      ar_pend_q    <= ar_pend_d;
      r_wait_q     <= r_wait_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      araddr_q     <= araddr_d;
      rst_cnt_q    <= rst_cnt_d;
      timer_q      <= timer_d;
      poll_due_q   <= poll_due_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
      link_up_q    <= link_up_d;
      link_valid_q <= link_valid_d;
      host_write_q <= host_write_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign axi_awvalid_o       = aw_pend_q;
  assign axi_awaddr_o        = awaddr_q;
  assign axi_wvalid_o        = w_pend_q;
  assign axi_wdata_o         = wdata_q;
  assign axi_bready_o        = b_wait_q;
  assign axi_arvalid_o       = ar_pend_q;
  assign axi_araddr_o        = araddr_q;
  assign axi_rready_o        = r_wait_q;
  assign host_req_ready_o    = (state_q == IDLE);
  assign host_rsp_valid_o    = rsp_valid_q;
  assign host_rsp_rdata_o    = rsp_rdata_q;
  assign init_done_o         = init_done_q;
  assign init_error_o        = init_error_q;
  assign link_up_o           = link_up_q;
  assign link_status_valid_o = link_valid_q;

endmodule

// File: tb/tb_mdio_phy_manager.sv
// tb_mdio_phy_manager
//   Directed sequence around an AXI-Lite slave with a behavioural PHY register
//   model and randomized ready/response timing. Every AXI access the PHY sees
//   is logged and compared with the access list expected from the bring-up,
//   polling and host rules.
module tb_mdio_phy_manager;

  localparam int unsigned POLL = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rvalid, axi_rready;
  logic [4:0]  axi_awaddr, axi_araddr;
  logic [15:0] axi_wdata, axi_rdata;
  logic        host_req_valid, host_req_ready, host_req_write;
  logic [4:0]  host_req_addr;
  logic [15:0] host_req_wdata;
  logic        host_rsp_valid;
  logic [15:0] host_rsp_rdata;
  logic        init_done, init_error, link_up, link_status_valid;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // PHY model state
  logic [15:0] phy_regs [32];
  int          phy_rst_left;
  int          phy_clear_after;
  logic [15:0] bmsr;
  int          proto_err = 0;

  // Access log entries: {write, addr, data}
  logic [21:0] log_q [$];
  logic [21:0] exp_q [$];

  mdio_phy_manager #(
    .POLL_INTERVAL_CYCLES(POLL)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .axi_awvalid_o       (axi_awvalid),
    .axi_awaddr_o        (axi_awaddr),
    .axi_awready_i       (axi_awready),
    .axi_wvalid_o        (axi_wvalid),
    .axi_wdata_o         (axi_wdata),
    .axi_wready_i        (axi_wready),
    .axi_bvalid_i        (axi_bvalid),
    .axi_bready_o        (axi_bready),
    .axi_arvalid_o       (axi_arvalid),
    .axi_araddr_o        (axi_araddr),
    .axi_arready_i       (axi_arready),
    .axi_rvalid_i        (axi_rvalid),
    .axi_rdata_i         (axi_rdata),
    .axi_rready_o        (axi_rready),
    .host_req_valid_i    (host_req_valid),
    .host_req_ready_o    (host_req_ready),
    .host_req_write_i    (host_req_write),
    .host_req_addr_i     (host_req_addr),
    .host_req_wdata_i    (host_req_wdata),
    .host_rsp_valid_o    (host_rsp_valid),
    .host_rsp_rdata_o    (host_rsp_rdata),
    .init_done_o         (init_done),
    .init_error_o        (init_error),
    .link_up_o           (link_up),
    .link_status_valid_o (link_status_valid)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic phy_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0 && d[15]) begin
      phy_regs[0] = d & 16'h7FFF;
      phy_rst_left = phy_clear_after - 1;
    end else begin
      phy_regs[a] = d;
    end
  endtask

  task automatic phy_read(input logic [4:0] a, output logic [15:0] v);
    if (a == 5'd0) begin
      if (phy_rst_left > 0) begin
        phy_rst_left--;
        v = phy_regs[0] | 16'h8000;
      end else begin
        v = phy_regs[0];
      end
    end else if (a == 5'd1) begin
      v = bmsr;
    end else begin
      v = phy_regs[a];
    end
  endtask

  // AXI-Lite slave: handshakes are decided from values held stable over the
  // negative edge, reactions are applied just after the following posedge.
  initial begin
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s;
    bit          have_aw, have_w, have_ar;
    logic [4:0]  s_aw, s_ar, n_aw, n_ar;
    logic [15:0] s_wd, n_wd, v;
    have_aw = 0; have_w = 0; have_ar = 0;
    s_aw = 0; s_ar = 0; s_wd = 0;
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_bvalid = 0; axi_rvalid = 0; axi_rdata = 0;
    forever begin
      @(negedge clk);
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      b_hs  = axi_bvalid && axi_bready;
      ar_hs = axi_arvalid && axi_arready;
      r_hs  = axi_rvalid && axi_rready;
      n_aw  = axi_awaddr;
      n_wd  = axi_wdata;
      n_ar  = axi_araddr;
      rst_s = reset;
      if ((axi_awvalid || axi_wvalid || axi_bready) && (axi_arvalid || axi_rready))
        proto_err++;
      @(posedge clk);
      #1;
      if (rst_s) begin
        have_aw = 0; have_w = 0; have_ar = 0;
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_bvalid = 0; axi_rvalid = 0;
      end else begin
        if (aw_hs) begin have_aw = 1; s_aw = n_aw; end
        if (w_hs)  begin have_w = 1;  s_wd = n_wd; end
        if (ar_hs) begin have_ar = 1; s_ar = n_ar; end
        if (b_hs) axi_bvalid = 0;
        if (r_hs) axi_rvalid = 0;
        if (have_aw && have_w && !axi_bvalid && $urandom_range(0, 1) == 1) begin
          phy_write(s_aw, s_wd);
          log_q.push_back({1'b1, s_aw, s_wd});
          $display("[%0d] axi write reg %0d = %h", cyc, s_aw, s_wd);
          axi_bvalid = 1; have_aw = 0; have_w = 0;
        end
        if (have_ar && !axi_rvalid && $urandom_range(0, 1) == 1) begin
          phy_read(s_ar, v);
          log_q.push_back({1'b0, s_ar, v});
          $display("[%0d] axi read  reg %0d -> %h", cyc, s_ar, v);
          axi_rdata = v; axi_rvalid = 1; have_ar = 0;
        end
        axi_awready = !have_aw && ($urandom_range(0, 1) == 1);
        axi_wready  = !have_w  && ($urandom_range(0, 1) == 1);
        axi_arready = !have_ar && ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic host_xfer(input string tag, input logic wr, input logic [4:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rdata);
    int n;
    bit acc;
    host_req_write = wr; host_req_addr = a; host_req_wdata = d;
    host_req_valid = 1;
    acc = 0; n = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = host_req_valid && host_req_ready;
      @(posedge clk); #1;
      n++;
    end
    host_req_valid = 0;
    check({tag, "_accept"}, 32'(acc), 32'd1);
    n = 0;
    while (!host_rsp_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(host_rsp_valid), 32'd1);
    check({tag, "_rsp_rdata"}, 32'(host_rsp_rdata), 32'(exp_rdata));
    $display("[%0d] host %s reg %0d wdata %h rdata %h", cyc, wr ? "write" : "read", a, d, host_rsp_rdata);
    @(posedge clk); #1;
    check({tag, "_rsp_pulse"}, 32'(host_rsp_valid), 32'd0);
    check({tag, "_rdata_hold"}, 32'(host_rsp_rdata), 32'(exp_rdata));
  endtask

  // Wait for a complete two-read poll to finish and the DUT to be back in IDLE.
  task automatic wait_poll(input int budget);
    int n;
    n = 0;
    while (!(log_q.size() >= 2 && host_req_ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int          n;
    int          init_cyc;
    int          w;
    logic [15:0] b;
    logic [4:0]  ha;
    logic [15:0] hd;

    reset = 1;
    host_req_valid = 0; host_req_write = 0; host_req_addr = 0; host_req_wdata = 0;
    for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0000;
    phy_regs[2] = 16'h0022;
    phy_clear_after = 2;
    phy_rst_left = 0;
    bmsr = 16'h7869;

    // ---- reset state ----
    repeat (4) @(posedge clk);
    #1;
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_error", 32'(init_error), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_link_valid", 32'(link_status_valid), 32'd0);
    check("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    check("rst_req_ready", 32'(host_req_ready), 32'd0);
    check("rst_awvalid", 32'(axi_awvalid), 32'd0);
    check("rst_arvalid", 32'(axi_arvalid), 32'd0);

    // ---- bring-up, reset bit clears on the 2nd read ----
    log_q.delete();
    reset = 0;
    @(posedge clk); #1;
    check("init_req_ready", 32'(host_req_ready), 32'd0);
    n = 0;
    while (!init_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    init_cyc = cyc;
    check("init_done", 32'(init_done), 32'd1);
    check("init_error", 32'(init_error), 32'd0);
    exp_q.delete();
    exp_q.push_back({1'b1, 5'd0, 16'h8000});
    exp_q.push_back({1'b0, 5'd0, 16'h8000});
    exp_q.push_back({1'b0, 5'd0, 16'h0000});
    exp_q.push_back({1'b1, 5'd4, 16'h01E1});
    exp_q.push_back({1'b1, 5'd0, 16'h1200});
    check_log("init_seq");

    // ---- link polling ----
    bmsr = 16'h786D;
    log_q.delete();
    wait_poll(POLL + 2000);
    check("poll1_link_up", 32'(link_up), 32'd1);
    check("poll1_link_valid", 32'(link_status_valid), 32'd1);
    exp_q.delete();
    exp_q.push_back({1'b0, 5'd1, 16'h786D});
    exp_q.push_back({1'b0, 5'd1, 16'h786D});
    check_log("poll1_seq");
    for (int j = 0; j < 3; j++) begin
      b = (j == 0) ? 16'h7869 : 16'($urandom);
      bmsr = b;
      log_q.delete();
      wait_poll(POLL + 2000);
      check($sformatf("poll%0d_link_up", j + 2), 32'(link_up), 32'(b[2]));
      exp_q.delete();
      exp_q.push_back({1'b0, 5'd1, b});
      exp_q.push_back({1'b0, 5'd1, b});
      check_log($sformatf("poll%0d_seq", j + 2));
    end

    // ---- host accesses in IDLE ----
    log_q.delete();
    host_xfer("host_rd2", 1'b0, 5'd2, 16'h0000, 16'h0022);
    exp_q.delete();
    exp_q.push_back({1'b0, 5'd2, 16'h0022});
    check_log("host_rd2_seq");

    ha = 5'($urandom_range(5, 30));
    hd = 16'($urandom);
    log_q.delete();
    host_xfer("host_wr_rand", 1'b1, ha, hd, 16'h0000);
    host_xfer("host_rd_rand", 1'b0, ha, 16'h0000, hd);
    exp_q.delete();
    exp_q.push_back({1'b1, ha, hd});
    exp_q.push_back({1'b0, ha, hd});
    check_log("host_rand_seq");

    // ---- host write presented on the edge where the poll becomes due ----
    w = init_cyc + ((cyc - init_cyc) / POLL + 1) * POLL;
    if (w - 1 <= cyc + 2) w += POLL;
    do begin
      @(posedge clk); #1;
    end while (cyc != w - 1);
    b = 16'h786D;
    bmsr = b;
    log_q.delete();
    host_xfer("host_vs_poll", 1'b1, 5'h1F, 16'hABCD, 16'h0000);
    n = 0;
    while (!(log_q.size() >= 3 && host_req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    exp_q.delete();
    exp_q.push_back({1'b1, 5'h1F, 16'hABCD});
    exp_q.push_back({1'b0, 5'd1, b});
    exp_q.push_back({1'b0, 5'd1, b});
    check_log("host_vs_poll_seq");

    // ---- reset in the middle of the reset-poll read ----
    phy_clear_after = 1000;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    log_q.delete();
    reset = 0;
    n = 0;
    while (!(log_q.size() >= 1 && axi_arvalid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_in_read", 32'(axi_arvalid), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    check("midrst_arvalid", 32'(axi_arvalid), 32'd0);
    check("midrst_rready", 32'(axi_rready), 32'd0);
    check("midrst_awvalid", 32'(axi_awvalid), 32'd0);
    check("midrst_wvalid", 32'(axi_wvalid), 32'd0);
    check("midrst_bready", 32'(axi_bready), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_link_valid", 32'(link_status_valid), 32'd0);
    check("midrst_link_up", 32'(link_up), 32'd0);

    // ---- restart with a PHY that never leaves reset ----
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    reset = 0;
    n = 0;
    while (!init_error && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("err_init_error", 32'(init_error), 32'd1);
    check("err_init_done", 32'(init_done), 32'd0);
    check("err_req_ready", 32'(host_req_ready), 32'd1);
    exp_q.delete();
    exp_q.push_back({1'b1, 5'd0, 16'h8000});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 5'd0, 16'h8000});
    check_log("err_seq");
    log_q.delete();
    repeat (2 * POLL + 500) @(posedge clk);
    #1;
    check("err_no_poll", 32'(log_q.size()), 32'd0);
    check("err_link_valid", 32'(link_status_valid), 32'd0);
    host_xfer("err_host_rd2", 1'b0, 5'd2, 16'h0000, 16'h0022);

    check("axi_rw_overlap", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdio_phy_manager.md
Name: mdio_phy_manager

Overview:
- Sequences the MDIO master over its AXI-Lite slave port: brings up the Ethernet PHY after reset, then periodically polls link status.
- Soft-resets the PHY, waits for reset to self-clear, programs auto-negotiation advertisement, restarts auto-negotiation, then polls BMSR.
- Arbitrates a single host register-access port onto the same MDIO master so software/debug logic can read and write PHY registers between polls.

Parameters:
- POLL_INTERVAL_CYCLES, 12_500_000, clk cycles between link polls (100 ms at 125 MHz).
- RESET_POLL_LIMIT, 16, max BMCR reads waiting for reset bit 15 to clear before error.
- ANAR_VALUE, 16'h01E1, value written to register 4 (advertise 10/100 full/half, IEEE 802.3).
- BMCR_ANEG_VALUE, 16'h1200, value written to register 0 to enable and restart auto-negotiation.

Ports:
- clk  in  1  system clock (125 MHz).
- reset  in  1  synchronous, active-high.
- axi_lite  axi_lite_interface.Master  -  to mdio_master; 5-bit register address, 16-bit data.
- host_req_valid  in  1  host request present.
- host_req_ready  out  1  request accepted on valid && ready.
- host_req_write  in  1  1 = write, 0 = read.
- host_req_addr  in  5  PHY register address.
- host_req_wdata  in  16  write data.
- host_rsp_valid  out  1  one-cycle pulse at host transaction completion.
- host_rsp_rdata  out  16  read data; 0 for writes; held until next response.
- init_done  out  1  high once the init sequence completes; sticky until reset.
- init_error  out  1  reset-poll limit exceeded; sticky until reset.
- link_up  out  1  BMSR bit 2 from latest poll.
- link_status_valid  out  1  high after first completed poll; sticky.

Behaviour:
- Clock: clk. Reset: reset, synchronous, active-high. All outputs and AXI valid/ready signals 0; state -> RST_WR; poll timer and reset-poll counter cleared.
- AXI write transaction:
  - Assert awvalid+awaddr and wvalid+wdata together.
  - Drop each independently on its handshake.
  - After both handshakes, assert bready until bvalid && bready. bresp is ignored.
- AXI read transaction:
  - Assert arvalid+araddr until arready.
  - Then assert rready until rvalid && rready; capture rdata.
  - Never run a read and a write concurrently.
- States (each write/read state completes its full transaction before transitioning):
  - RST_WR: write reg 0 = 16'h8000 -> RST_POLL.
  - RST_POLL: read reg 0. If bit 15 = 0 -> ANAR_WR. Otherwise increment counter; when the count reaches RESET_POLL_LIMIT set init_error and go to IDLE; else repeat RST_POLL.
  - ANAR_WR: write reg 4 = ANAR_VALUE -> ANEG_WR.
  - ANEG_WR: write reg 0 = BMCR_ANEG_VALUE; set init_done -> IDLE.
  - IDLE:
    - host_req_ready = 1 (combinational with state IDLE).
    - Host accept latches write/addr/wdata -> HOST_XFER.
    - Otherwise, if poll_due && !init_error -> POLL1.
    - Host has priority when both are pending; the poll runs on the next IDLE visit.
  - HOST_XFER: perform host read/write. On completion pulse host_rsp_valid for 1 cycle with rdata (or 0) -> IDLE.
  - POLL1: read reg 1 and discard (clears the latched-low link bit) -> POLL2.
  - POLL2: read reg 1; link_up <= rdata[2]; link_status_valid <= 1; clear poll_due -> IDLE.
- Poll timer:
  - Free-running once init_done || init_error.
  - Counts 0..POLL_INTERVAL_CYCLES-1, wraps, and sets sticky poll_due on wrap.
  - A wrap while poll_due is already set is absorbed; at most one poll is pending.
- host_req_ready is 0 in every state except IDLE, including during init and when init_error is set. IDLE still serves host requests after an error.
- Reset mid-transaction: all valids drop next cycle with no completion. mdio_master shares reset, so no orphaned handshake.
- Widths: the reset-poll counter is $clog2(RESET_POLL_LIMIT)+1 bits; the poll timer is $clog2(POLL_INTERVAL_CYCLES) bits.

Test Plan (bench: mdio_master + behavioural PHY model, POLL_INTERVAL_CYCLES=5000):
- Reset release, PHY clears BMCR[15] on 2nd read -> MDIO writes reg0=8000, 2 reads of reg0, reg4=01E1, reg0=1200; init_done=1, init_error=0.
- PHY holds BMCR[15]=1 forever -> exactly 16 reads of reg0, then init_error=1, init_done=0, and no further reg1 polls.
- PHY BMSR=0x786D (link bit set) after init -> two reg1 reads per interval; link_up=1 and link_status_valid=1 after the first poll; BMSR=0x7869 -> link_up=0 after the next poll.
- Host read reg 2 in IDLE, PHY returns 0x0022 -> single read frame; host_rsp_valid pulses once with rdata=0x0022.
- Host write reg 0x1F=0xABCD asserted in the same cycle poll_due sets -> host write frame precedes both BMSR reads; host_rsp_rdata=0.
- Assert reset during the RST_POLL read -> all AXI valids low next cycle; the sequence restarts from RST_WR; outputs return to 0.
